// File: rtl/trace_trigger_reader.sv
// trace_trigger_reader: finds the first trigger crossing in the capture buffer, then streams TRACE_LEN aligned samples.
// Samples return RD_LAT cycles after address issue; no backpressure. `TRIG_SLOPE_SEL_EN adds the trig_falling select.
module trace_trigger_reader #(
   parameter int BUF_LEN   = 800,
   parameter int TRACE_LEN = 400,
   parameter int RD_LAT    = 2,
   parameter int DW        = 12,
   parameter int AW        = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] trig_level,
`ifdef TRIG_SLOPE_SEL_EN
   input  logic          trig_falling,
`endif
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic [DW-1:0] sample_out,
   output logic [AW-1:0] sample_col,
   output logic          sample_valid,
   output logic          busy,
   output logic          trig_found,
   output logic          done
);
   typedef enum logic [2:0] {IDLE, SEARCH, DRAIN, READ, FLUSH} state_t;

   localparam logic [AW-1:0] SRCH_LAST = AW'(BUF_LEN - TRACE_LEN - 1);
   localparam logic [AW-1:0] COL_LAST  = AW'(TRACE_LEN - 1);

   state_t            state, state_nxt;
   logic [DW-1:0]     lvl;
   logic [DW-1:0]     prev_dat;
   logic              fall;
   logic [AW-1:0]     trig_idx;
   logic              srch_end;
   logic [RD_LAT-1:0] tag_vld;
   logic [AW-1:0]     tag_addr [RD_LAT];
   logic              iss;
   logic              hit;
   logic              ret_vld;
   logic              pipe_empty;
   logic [AW-1:0]     ret_addr;
   logic [AW-1:0]     rd_col;

`ifdef TRIG_SLOPE_SEL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fall <= 1'b0;
      else if (state == IDLE && start)
         fall <= trig_falling;
   end
`else
   assign fall = 1'b0;
`endif

   // the tail of the tag pipe lines up with rd_data
   assign ret_vld    = tag_vld[RD_LAT-1];
   assign ret_addr   = tag_addr[RD_LAT-1];
   assign pipe_empty = (tag_vld == '0);
   assign rd_col     = rd_addr - trig_idx;

   always_comb begin
      hit = 1'b0;
      if (state == SEARCH && ret_vld && ret_addr != '0) begin
         if (fall)
            hit = (prev_dat > lvl) && (rd_data <= lvl);
         else
            hit = (prev_dat < lvl) && (rd_data >= lvl);
      end
   end

   assign iss = (state == SEARCH && !srch_end && !hit) || (state == READ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = SEARCH;
         SEARCH:  if (hit || (ret_vld && ret_addr == SRCH_LAST)) state_nxt = DRAIN;
         DRAIN:   if (pipe_empty) state_nxt = READ;
         READ:    if (rd_col == COL_LAST) state_nxt = FLUSH;
         FLUSH:   if (pipe_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy         = 1'b0;
      done         = 1'b0;
      sample_valid = 1'b0;
      sample_out   = '0;
      sample_col   = '0;
      unique case (state)
         SEARCH, DRAIN: busy = 1'b1;
         READ, FLUSH: begin
            done = (state == FLUSH) && pipe_empty;
            busy = !done;
            if (ret_vld) begin
               sample_valid = 1'b1;
               sample_out   = rd_data;
               sample_col   = ret_addr - trig_idx;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr    <= '0;
         lvl        <= '0;
         prev_dat   <= '0;
         trig_idx   <= '0;
         trig_found <= 1'b0;
         srch_end   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               lvl        <= trig_level;
               rd_addr    <= '0;
               trig_idx   <= '0;
               trig_found <= 1'b0;
               srch_end   <= 1'b0;
            end
            SEARCH: begin
               if (iss) begin
                  if (rd_addr == SRCH_LAST)
                     srch_end <= 1'b1;
                  else
                     rd_addr <= rd_addr + 1'b1;
               end
               if (ret_vld)
                  prev_dat <= rd_data;
               if (hit) begin
                  trig_idx   <= ret_addr;
                  trig_found <= 1'b1;
               end
            end
            DRAIN: if (pipe_empty) rd_addr <= trig_idx;
            READ:  if (rd_col != COL_LAST) rd_addr <= rd_addr + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld <= '0;
         for (int i = 0; i < RD_LAT; i++)
            tag_addr[i] <= '0;
      end else begin
         tag_vld[0]  <= iss;
         tag_addr[0] <= rd_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i]  <= tag_vld[i-1];
            tag_addr[i] <= tag_addr[i-1];
         end
      end
   end

endmodule
